// File: rtl/ext_bus_initiator.sv
// Request/ack bus initiator: one command in flight, registered bus strobes,
// bounded wait for the responder's acknowledge, stray-ack reporting.
module ext_bus_initiator #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wr_data,
  input  logic [WIDTH-1:0]      cmd_wr_biten,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_is_wr,
  output logic [WIDTH-1:0]      resp_rd_data,
  output logic                  resp_timeout,
  output logic                  req,
  output logic                  req_is_wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      wr_biten,
  input  logic                  rd_ack,
  input  logic [WIDTH-1:0]      rd_data,
  input  logic                  wr_ack,
  output logic                  stray_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    cmd_ready_q;
  logic                    req_q;
  logic                    req_is_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wr_data_q;
  logic [WIDTH-1:0]        wr_biten_q;
  logic                    resp_valid_q;
  logic                    resp_is_wr_q;
  logic [WIDTH-1:0]        resp_rd_data_q;
  logic                    resp_timeout_q;
  logic                    stray_q;

  logic                    exp_ack;
  logic                    wrong_ack;
  logic [CW-1:0]           cnt_d;
  logic                    last_edge;
  logic                    stray_d;

  // cnt_q holds edges already sampled; cnt_d is the index of the current edge.
  always_comb begin
    exp_ack   = req_is_wr_q ? wr_ack : rd_ack;
    wrong_ack = req_is_wr_q ? rd_ack : wr_ack;
    cnt_d     = cnt_q + CW'(1);
    last_edge = (cnt_d == CW'(TIMEOUT));
    stray_d   = ((state_q == IDLE) || (state_q == RESP)) ? (rd_ack | wr_ack) : wrong_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cmd_ready_q    <= 1'b0;
      req_q          <= 1'b0;
      req_is_wr_q    <= 1'b0;
      addr_q         <= '0;
      wr_data_q      <= '0;
      wr_biten_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_is_wr_q   <= 1'b0;
      resp_rd_data_q <= '0;
      resp_timeout_q <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      stray_q <= stray_d;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b1;
            req_is_wr_q <= cmd_is_wr;
            addr_q      <= cmd_addr;
            wr_data_q   <= cmd_wr_data;
            wr_biten_q  <= cmd_wr_biten;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ, WAIT: begin
          req_q <= 1'b0;
          cnt_q <= cnt_d;
          // An ack on the final counted edge still completes normally.
          if (exp_ack) begin
            resp_valid_q   <= 1'b1;
            resp_is_wr_q   <= req_is_wr_q;
            resp_timeout_q <= 1'b0;
            resp_rd_data_q <= req_is_wr_q ? '0 : rd_data;
            state_q        <= RESP;
          end else if (last_edge) begin
            resp_valid_q   <= 1'b1;
            resp_is_wr_q   <= req_is_wr_q;
            resp_timeout_q <= 1'b1;
            resp_rd_data_q <= '0;
            state_q        <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign req          = req_q;
  assign req_is_wr    = req_is_wr_q;
  assign addr         = addr_q;
  assign wr_data      = wr_data_q;
  assign wr_biten     = wr_biten_q;
  assign resp_valid   = resp_valid_q;
  assign resp_is_wr   = resp_is_wr_q;
  assign resp_rd_data = resp_rd_data_q;
  assign resp_timeout = resp_timeout_q;
  assign stray_ack    = stray_q;

endmodule

// File: tb/tb_ext_bus_initiator.sv
// Bench for ext_bus_initiator: directed scenarios then randomized commands,
// each checked against the expected completion edge, type, data and timeout.
module tb_ext_bus_initiator;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_is_wr;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_wr_data;
  logic [W-1:0]  cmd_wr_biten;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_is_wr;
  logic [W-1:0]  resp_rd_data;
  logic          resp_timeout;
  logic          req;
  logic          req_is_wr;
  logic [AW-1:0] addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  wr_biten;
  logic          rd_ack;
  logic [W-1:0]  rd_data;
  logic          wr_ack;
  logic          stray_ack;

  int checks   = 0;
  int failures = 0;

  ext_bus_initiator #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .cmd_wr_biten(cmd_wr_biten),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_wr(resp_is_wr),
    .resp_rd_data(resp_rd_data), .resp_timeout(resp_timeout),
    .req(req), .req_is_wr(req_is_wr), .addr(addr), .wr_data(wr_data),
    .wr_biten(wr_biten), .rd_ack(rd_ack), .rd_data(rd_data), .wr_ack(wr_ack),
    .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ack_k: cycle (1 = the req cycle) in which the responder acks; 0 = silent.
  task automatic run_cmd(input logic is_wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] b, input int ack_k, input logic wrong_first,
                         input logic [W-1:0] rv, input int hold, input logic late);
    int          exp_edge;
    logic        exp_to;
    logic [W-1:0] exp_rd;
    logic        seen;
    logic        wrong_now;
    exp_to   = !(ack_k >= 1 && ack_k <= T);
    exp_edge = exp_to ? T : ack_k;
    exp_rd   = (is_wr || exp_to) ? '0 : rv;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid    = 1'b1;
    cmd_is_wr    = is_wr;
    cmd_addr     = a;
    cmd_wr_data  = d;
    cmd_wr_biten = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd_addr     = AW'($urandom);
    cmd_wr_data  = $urandom;
    cmd_wr_biten = $urandom;
    check("req_high", 64'(req), 64'(1));
    check("req_is_wr", 64'(req_is_wr), 64'(is_wr));
    check("req_addr", 64'(addr), 64'(a));
    check("req_wr_data", 64'(wr_data), 64'(d));
    check("req_wr_biten", 64'(wr_biten), 64'(b));
    check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    check("resp_valid_req", 64'(resp_valid), 64'(0));
    seen = 1'b0;
    for (int c = 1; c <= T + 4 && !seen; c++) begin
      wrong_now = wrong_first && (c == ack_k - 1);
      if (!exp_to && c == ack_k) begin
        if (is_wr) wr_ack = 1'b1;
        else       rd_ack = 1'b1;
      end
      if (wrong_now) begin
        if (is_wr) rd_ack = 1'b1;
        else       wr_ack = 1'b1;
      end
      rd_data = (rd_ack && !is_wr) ? rv : $urandom;
      @(posedge clk);
      @(negedge clk);
      rd_ack  = 1'b0;
      wr_ack  = 1'b0;
      rd_data = $urandom;
      check("req_low", 64'(req), 64'(0));
      check("addr_hold", 64'(addr), 64'(a));
      check("stray_wait", 64'(stray_ack), 64'(wrong_now));
      check("resp_valid_edge", 64'(resp_valid), 64'(c == exp_edge));
      if (resp_valid) seen = 1'b1;
    end
    check("resp_seen", 64'(seen), 64'(1));
    check("resp_is_wr", 64'(resp_is_wr), 64'(is_wr));
    check("resp_timeout", 64'(resp_timeout), 64'(exp_to));
    check("resp_rd_data", 64'(resp_rd_data), 64'(exp_rd));
    for (int h = 0; h < hold; h++) begin
      rd_ack = late && (h == 1);
      @(posedge clk);
      @(negedge clk);
      rd_ack = 1'b0;
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_rd_data", 64'(resp_rd_data), 64'(exp_rd));
      check("hold_timeout", 64'(resp_timeout), 64'(exp_to));
      check("hold_is_wr", 64'(resp_is_wr), 64'(is_wr));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      check("hold_stray", 64'(stray_ack), 64'(late && (h == 1)));
      check("hold_addr", 64'(addr), 64'(a));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done", 64'(resp_valid), 64'(0));
    check("cmd_ready_back", 64'(cmd_ready), 64'(1));
    check("stray_quiet", 64'(stray_ack), 64'(0));
  endtask

  initial begin
    logic        r_wr;
    logic        r_wrong;
    logic        r_late;
    int          r_k;
    int          r_hold;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0; cmd_wr_biten = '0;
    resp_ready = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(req), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_stray", 64'(stray_ack), 64'(0));
    rst = 1'b0;

    // Directed scenarios.
    run_cmd(1'b1, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1'b0, 32'h0, 0, 1'b0);
    run_cmd(1'b0, 8'h04, 32'h0, 32'h0, 4, 1'b0, 32'hDEADBEEF, 0, 1'b0);
    run_cmd(1'b0, 8'h20, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4, 1'b1);
    run_cmd(1'b0, 8'h30, 32'h0, 32'h0, T, 1'b0, 32'hA5A5_1234, 0, 1'b0);
    run_cmd(1'b0, 8'h40, 32'h0, 32'h0, 3, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
    run_cmd(1'b1, 8'h44, 32'h1234_5678, 32'h00FF_00FF, 2, 1'b0, 32'h0, 5, 1'b0);

    // Reset during the req cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 8'h50;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rreq_req_high", 64'(req), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("rreq_req_drop", 64'(req), 64'(0));
    check("rreq_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rreq_ready_after", 64'(cmd_ready), 64'(1));

    // Reset while waiting for a read ack, then a late ack.
    cmd_valid = 1'b1; cmd_is_wr = 1'b0; cmd_addr = 8'h60;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rwait_req", 64'(req), 64'(0));
    check("rwait_resp_valid", 64'(resp_valid), 64'(0));
    check("rwait_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    rd_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_ack = 1'b0;
    check("rwait_late_stray", 64'(stray_ack), 64'(1));
    check("rwait_no_resp", 64'(resp_valid), 64'(0));
    check("rwait_ready", 64'(cmd_ready), 64'(1));
    run_cmd(1'b1, 8'h64, 32'hCAFE_0001, 32'hFFFF_0000, 2, 1'b0, 32'h0, 1, 1'b0);

    // Randomized commands.
    for (int i = 0; i < 24; i++) begin
      r_wr    = 1'($urandom);
      r_k     = int'($urandom_range(0, 19));
      if (r_k > T) r_k = 0;
      r_wrong = (r_k >= 2) && 1'($urandom);
      r_hold  = int'($urandom_range(0, 3));
      r_late  = (r_hold >= 2) && 1'($urandom);
      run_cmd(r_wr, AW'($urandom), $urandom, $urandom, r_k, r_wrong, $urandom, r_hold, r_late);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
